data_mem_responder: RTL and testbench

Wait-stated data-memory responder serving the CPU's load/store port over a req/ack handshake. Holds a word-addressed RAM, accepts one transaction at a time, inserts a programmable number of wait cycles, then returns read data or commits write data with a one-cycle acknowledge. It flags misaligned and out-of-range accesses instead of performing them. It sits between the CPU datapath (initiator) and the data storage.

---
 rtl/data_mem_responder_pkg.sv | 28 ++
 rtl/data_mem_responder_mem_array_1p.sv | 41 ++++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Shared constants for the wait-stated data-memory responder:
//               FSM state encoding, word width, default geometry/timing and
//               the access-rejection decode.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

  localparam int WORD_W              = 32;
  localparam int CNT_W               = 4;
  localparam int DEFAULT_DEPTH_LOG2  = 6;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // An access is rejected when it is not word aligned or when any byte-address
  // bit above the RAM's word index is set.
  function automatic logic addr_rejected(input logic [WORD_W-1:0] addr,
                                         input int                depth_log2);
    return (addr[1:0] != 2'b00) || ((addr >> (depth_log2 + 2)) != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_mem_array_1p.sv
`default_nettype none
// ============================================================================
// Module      : mem_array_1p
// Description : Single-port RAM, synchronous write and synchronous read. The
//               read register doubles as the responder's load-data output, so
//               it clears to zero on store, on clr, and otherwise holds.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array_1p #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic                  clr,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  // Storage array: write only when the access is enabled and is a store.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register: loads return the word, stores and clears return zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? '0 : mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Wait-stated data-memory responder on a req/ack handshake.
//               Accepts one request in IDLE, counts WAIT_CYCLES, then in a
//               single RESP cycle pulses Ack with Err and RData. Misaligned
//               or out-of-range accesses are flagged and not performed.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              We,
  input  logic [WORD_W-1:0] Addr,
  input  logic [WORD_W-1:0] WData,
  output logic [WORD_W-1:0] RData,
  output logic              Ack,
  output logic              Err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
  localparam bit               NO_WAIT  = (WAIT_CYCLES == 0);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  we_q;
  logic                  err_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [WORD_W-1:0]     wdata_q;
  logic                  ack_q;
  logic                  err_out_q;

  logic                  accept;
  logic                  enter_resp;
  logic                  addr_err;
  logic [DEPTH_LOG2-1:0] addr_idx;
  logic                  cur_we;
  logic                  cur_err;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [WORD_W-1:0]     cur_wdata;
  logic                  mem_en;
  logic                  mem_clr;

  // Request decode and selection of the fields that reach the RAM. With no
  // wait states RESP is entered on the accepting edge, so the live inputs
  // are used; otherwise the fields latched at acceptance are used.
  always_comb begin
    addr_idx   = Addr[DEPTH_LOG2+1:2];
    addr_err   = addr_rejected(Addr, DEPTH_LOG2);
    accept     = (state == ST_IDLE) && Req;
    enter_resp = (accept && NO_WAIT) || ((state == ST_WAIT) && (cnt == 4'd1));
    cur_we     = accept ? We       : we_q;
    cur_err    = accept ? addr_err : err_q;
    cur_idx    = accept ? addr_idx : idx_q;
    cur_wdata  = accept ? WData    : wdata_q;
    mem_en     = enter_resp && !cur_err && Reset;
    mem_clr    = !Reset || (state == ST_RESP) || (enter_resp && cur_err);
  end

  // Control FSM with the wait counter and the registered Ack/Err outputs.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ack_q     <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Req) begin
            if (NO_WAIT) begin
              state     <= ST_RESP;
              ack_q     <= 1'b1;
              err_out_q <= addr_err;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            state     <= ST_RESP;
            cnt       <= '0;
            ack_q     <= 1'b1;
            err_out_q <= err_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          ack_q     <= 1'b0;
          err_out_q <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          ack_q     <= 1'b0;
          err_out_q <= 1'b0;
        end
      endcase
    end
  end

  // Request latches: capture the transaction fields at acceptance only, so
  // input changes during WAIT have no effect.
  always_ff @(posedge Clock) begin
    if (accept) begin
      we_q    <= We;
      err_q   <= addr_err;
      idx_q   <= addr_idx;
      wdata_q <= WData;
    end
  end

  mem_array_1p #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WORD_W)
  ) u_mem (
    .clk   (Clock),
    .en    (mem_en),
    .we    (cur_we),
    .clr   (mem_clr),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (RData)
  );

  assign Ack = ack_q;
  assign Err = err_out_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. Two instances are
//               exercised: one with two wait cycles (A) and one with none (B),
//               against a word-array reference model of the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int DL      = 6;
  localparam int WORDS   = 64;
  localparam int WA      = 2;
  localparam int WB      = 0;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, we_a, ack_a, err_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        req_b, we_b, ack_b, err_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_a [WORDS];
  bit          known_a [WORDS];
  logic [31:0] model_b [WORDS];
  bit          known_b [WORDS];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WA)) dut_a (
    .Clock(clk), .Reset(rst_n), .Req(req_a), .We(we_a), .Addr(addr_a),
    .WData(wdata_a), .RData(rdata_a), .Ack(ack_a), .Err(err_a)
  );

  data_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WB)) dut_b (
    .Clock(clk), .Reset(rst_n), .Req(req_b), .We(we_b), .Addr(addr_b),
    .WData(wdata_b), .RData(rdata_b), .Ack(ack_b), .Err(err_b)
  );

  // Reference model: rejection from the address arithmetic, then a plain
  // word-array memory. e_known is 0 for loads of never-written words.
  task automatic model_txn(input bit use_b, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic e_err,
                           output logic [31:0] e_rd, output bit e_known);
    int idx;
    e_err   = (addr % 4 != 0) || (addr >= WORDS * 4);
    e_rd    = 32'h0;
    e_known = 1'b1;
    if (!e_err) begin
      idx = int'(addr / 4);
      if (wr) begin
        if (use_b) begin model_b[idx] = wdata; known_b[idx] = 1'b1; end
        else       begin model_a[idx] = wdata; known_a[idx] = 1'b1; end
      end else if (use_b ? known_b[idx] : known_a[idx]) begin
        e_rd = use_b ? model_b[idx] : model_a[idx];
      end else begin
        e_known = 1'b0;
      end
    end
  endtask

  // Drives one transaction: Req for the accepting edge, then the hold_* values
  // on the fields until Ack. Returns cycles from acceptance to Ack, the Ack
  // cycle's RData/Err, and whether all outputs were zero the cycle after.
  task automatic run_txn(input bit use_b, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] hold_addr,
                         input logic [31:0] hold_wdata, input logic hold_we,
                         output int lat, output logic [31:0] rd, output logic er,
                         output logic cleared);
    if (use_b) begin req_b = 1'b1; we_b = wr; addr_b = addr; wdata_b = wdata; end
    else       begin req_a = 1'b1; we_a = wr; addr_a = addr; wdata_a = wdata; end
    @(posedge clk); #1;
    if (use_b) begin req_b = 1'b0; we_b = hold_we; addr_b = hold_addr; wdata_b = hold_wdata; end
    else       begin req_a = 1'b0; we_a = hold_we; addr_a = hold_addr; wdata_a = hold_wdata; end
    lat = 0;
    while (((use_b ? ack_b : ack_a) !== 1'b1) && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = use_b ? rdata_b : rdata_a;
    er = use_b ? err_b : err_a;
    @(posedge clk); #1;
    cleared = use_b ? (ack_b === 1'b0 && err_b === 1'b0 && rdata_b === 32'h0)
                    : (ack_a === 1'b0 && err_a === 1'b0 && rdata_a === 32'h0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack_a, err_a, rdata_a} !== 34'h0)
      begin errors++; $display("FAIL reset_a: ack=%b err=%b rdata=%h, required all 0", ack_a, err_a, rdata_a); end
    checks++;
    if ({ack_b, err_b, rdata_b} !== 34'h0)
      begin errors++; $display("FAIL reset_b: ack=%b err=%b rdata=%h, required all 0", ack_b, err_b, rdata_b); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] rd; logic er, cl, e_err; logic [31:0] e_rd; bit kn;
    model_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, e_err, e_rd, kn);
    run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, $urandom, $urandom, 1'b1, lat, rd, er, cl);
    checks++; if (lat !== WA) begin errors++; $display("FAIL st_lat: got %0d want %0d", lat, WA); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL st_resp: err=%b rdata=%h want err=0 rdata=0", er, rd); end
    checks++; if (cl !== 1'b1) begin errors++; $display("FAIL st_clear: outputs not zero after Ack, got 0 want 1"); end
    model_txn(0, 1'b0, 32'h10, 32'h0, e_err, e_rd, kn);
    run_txn(0, 1'b0, 32'h10, 32'h0, $urandom, $urandom, 1'b1, lat, rd, er, cl);
    checks++; if (lat !== WA) begin errors++; $display("FAIL ld_lat: got %0d want %0d", lat, WA); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL ld_data: rdata=%h err=%b want DEADBEEF err=0", rd, er); end
    checks++; if (cl !== 1'b1) begin errors++; $display("FAIL ld_clear: outputs not zero after Ack, got 0 want 1"); end
  endtask

  task automatic test_misaligned;
    int lat; logic [31:0] rd; logic er, cl, e_err; logic [31:0] e_rd; bit kn;
    model_txn(0, 1'b1, 32'h13, 32'h12345678, e_err, e_rd, kn);
    run_txn(0, 1'b1, 32'h13, 32'h12345678, 32'h0, 32'h0, 1'b0, lat, rd, er, cl);
    checks++; if (lat !== WA) begin errors++; $display("FAIL mis_lat: got %0d want %0d", lat, WA); end
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_err: err=%b rdata=%h want err=1 rdata=0", er, rd); end
    checks++; if (cl !== 1'b1) begin errors++; $display("FAIL mis_clear: outputs not zero after Ack, got 0 want 1"); end
    run_txn(0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, lat, rd, er, cl);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL mis_keep: rdata=%h err=%b want DEADBEEF err=0", rd, er); end
  endtask

  task automatic test_out_of_range;
    int lat; logic [31:0] rd; logic er, cl;
    run_txn(0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, lat, rd, er, cl);
    checks++; if (lat !== WA) begin errors++; $display("FAIL oor_lat: got %0d want %0d", lat, WA); end
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_err: err=%b rdata=%h want err=1 rdata=0", er, rd); end
    run_txn(0, 1'b1, 32'h8000_0010, 32'h0BADF00D, 32'h0, 32'h0, 1'b0, lat, rd, er, cl);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_hi: err=%b want 1", er); end
    run_txn(0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, lat, rd, er, cl);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_keep: rdata=%h want DEADBEEF", rd); end
  endtask

  task automatic test_zero_wait_b2b;
    logic [31:0] a, d, e_rd; logic w, e_err; bit kn;
    req_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      begin w = 1'b1; a = 32'h4; d = 32'h1; end
      else if (i == 1) begin w = 1'b0; a = 32'h4; d = 32'h0; end
      else begin
        w = 1'($urandom_range(0, 1));
        a = 32'($urandom_range(0, 7)) * 4;
        d = $urandom;
      end
      we_b = w; addr_b = a; wdata_b = d;
      model_txn(1, w, a, d, e_err, e_rd, kn);
      @(posedge clk); #1;
      checks++; if (ack_b !== 1'b1) begin errors++; $display("FAIL b2b_ack op%0d: ack=%b want 1", i, ack_b); end
      checks++; if (err_b !== e_err) begin errors++; $display("FAIL b2b_err op%0d: err=%b want %b", i, err_b, e_err); end
      if (kn) begin
        checks++; if (rdata_b !== e_rd) begin errors++; $display("FAIL b2b_data op%0d: rdata=%h want %h", i, rdata_b, e_rd); end
      end
      @(posedge clk); #1;
      checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL b2b_gap op%0d: ack=%b want 0", i, ack_b); end
    end
    req_b = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic er, cl, e_err; logic [31:0] e_rd; bit kn;
    model_txn(0, 1'b1, 32'h8, 32'h11112222, e_err, e_rd, kn);
    run_txn(0, 1'b1, 32'h8, 32'h11112222, 32'h0, 32'h0, 1'b0, lat, rd, er, cl);
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h8; wdata_a = 32'hAAAA5555;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ack_a, err_a, rdata_a} !== 34'h0)
      begin errors++; $display("FAIL rst_mid: ack=%b err=%b rdata=%h want all 0", ack_a, err_a, rdata_a); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ack_a !== 1'b0) begin errors++; $display("FAIL rst_noack: ack=%b want 0", ack_a); end
    model_txn(0, 1'b0, 32'h8, 32'h0, e_err, e_rd, kn);
    run_txn(0, 1'b0, 32'h8, 32'h0, 32'h0, 32'h0, 1'b0, lat, rd, er, cl);
    checks++; if (lat !== WA) begin errors++; $display("FAIL rst_lat: got %0d want %0d", lat, WA); end
    checks++; if (rd !== e_rd) begin errors++; $display("FAIL rst_keep: rdata=%h want %h", rd, e_rd); end
  endtask

  task automatic test_hold_ignored;
    int lat; logic [31:0] rd; logic er, cl, e_err; logic [31:0] e_rd; bit kn;
    model_txn(0, 1'b1, 32'h24, 32'h55, e_err, e_rd, kn);
    run_txn(0, 1'b1, 32'h24, 32'h55, 32'h0, 32'h0, 1'b0, lat, rd, er, cl);
    model_txn(0, 1'b1, 32'h20, 32'hCAFEF00D, e_err, e_rd, kn);
    run_txn(0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h24, 32'h00000BAD, 1'b1, lat, rd, er, cl);
    run_txn(0, 1'b0, 32'h24, 32'h0, 32'h20, 32'h0, 1'b1, lat, rd, er, cl);
    checks++; if (rd !== 32'h55) begin errors++; $display("FAIL hold_other: rdata=%h want 00000055", rd); end
    run_txn(0, 1'b0, 32'h20, 32'h0, 32'h24, 32'h1, 1'b1, lat, rd, er, cl);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL hold_data: rdata=%h want CAFEF00D", rd); end
  endtask

  task automatic test_random;
    int lat, r; logic [31:0] rd, a, d, e_rd; logic er, cl, w, e_err; bit kn, ub;
    for (int i = 0; i < 48; i++) begin
      ub = (i % 4 == 3);
      r  = int'($urandom_range(0, 99));
      if (r < 70)      a = 32'($urandom_range(0, WORDS - 1)) * 4;
      else if (r < 85) a = 32'($urandom_range(0, WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
      else             a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0100;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      model_txn(ub, w, a, d, e_err, e_rd, kn);
      run_txn(ub, w, a, d, $urandom, $urandom, 1'($urandom_range(0, 1)), lat, rd, er, cl);
      checks++; if (lat !== (ub ? WB : WA)) begin errors++; $display("FAIL rnd_lat #%0d: got %0d want %0d", i, lat, ub ? WB : WA); end
      checks++; if (er !== e_err) begin errors++; $display("FAIL rnd_err #%0d addr=%h: err=%b want %b", i, a, er, e_err); end
      if (kn) begin
        checks++; if (rd !== e_rd) begin errors++; $display("FAIL rnd_data #%0d addr=%h: rdata=%h want %h", i, a, rd, e_rd); end
      end
      checks++; if (cl !== 1'b1) begin errors++; $display("FAIL rnd_clear #%0d: outputs not zero after Ack", i); end
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin known_a[i] = 1'b0; known_b[i] = 1'b0; end
    test_reset();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_zero_wait_b2b();
    test_reset_mid();
    test_hold_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
